// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: forwarding selects, stall/flush control, mul/div busy
// scoreboard, data-memory freeze and saturating stall-cycle counters.
module hazard_scoreboard #(
    parameter int RA_W       = 5,
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RA_W-1:0]  rs_d,
    input  logic [RA_W-1:0]  rt_d,
    input  logic [RA_W-1:0]  rs_e,
    input  logic [RA_W-1:0]  rt_e,
    input  logic [RA_W-1:0]  wa_e,
    input  logic [RA_W-1:0]  wa_m,
    input  logic [RA_W-1:0]  wa_w,
    input  logic             we_reg_e,
    input  logic             we_reg_m,
    input  logic             we_reg_w,
    input  logic             load_e,
    input  logic             load_m,
    input  logic             branch_d,
    input  logic             jr_d,
    input  logic             md_start_d,
    input  logic             md_start_e,
    input  logic             hilo_read_d,
    input  logic             dmem_stall,
    input  logic             cnt_clr,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             forward_ad,
    output logic             forward_bd,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_e,
    output logic             flush_w,
    output logic             md_busy,
    output logic [CNT_W-1:0] hazard_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt
);

    localparam int MD_W = $clog2(MD_LATENCY + 1);

    logic [MD_W-1:0]  r_md_cnt;
    logic [CNT_W-1:0] r_haz_cnt;
    logic [CNT_W-1:0] r_mem_cnt;

    logic w_rs_e_m, w_rt_e_m, w_rs_e_w, w_rt_e_w;
    logic w_rs_d_e, w_rt_d_e, w_rs_d_m, w_rt_d_m;
    logic w_lw_stall, w_br_stall, w_jr_stall, w_md_stall, w_hazard;

    // A hit is an address match against a nonzero source register.
    assign w_rs_e_m = (rs_e != '0) && (rs_e == wa_m);
    assign w_rt_e_m = (rt_e != '0) && (rt_e == wa_m);
    assign w_rs_e_w = (rs_e != '0) && (rs_e == wa_w);
    assign w_rt_e_w = (rt_e != '0) && (rt_e == wa_w);
    assign w_rs_d_e = (rs_d != '0) && (rs_d == wa_e);
    assign w_rt_d_e = (rt_d != '0) && (rt_d == wa_e);
    assign w_rs_d_m = (rs_d != '0) && (rs_d == wa_m);
    assign w_rt_d_m = (rt_d != '0) && (rt_d == wa_m);

    always_comb begin
        forward_ae = 2'b00;
        forward_be = 2'b00;
        if (w_rs_e_m && we_reg_m)      forward_ae = 2'b10;
        else if (w_rs_e_w && we_reg_w) forward_ae = 2'b01;
        if (w_rt_e_m && we_reg_m)      forward_be = 2'b10;
        else if (w_rt_e_w && we_reg_w) forward_be = 2'b01;
    end

    assign forward_ad = w_rs_d_m && we_reg_m;
    assign forward_bd = w_rt_d_m && we_reg_m;

    assign md_busy    = (r_md_cnt != '0);
    assign w_lw_stall = load_e && (w_rs_d_e || w_rt_d_e);
    assign w_br_stall = branch_d && ((we_reg_e && (w_rs_d_e || w_rt_d_e)) ||
                                     (load_m && (w_rs_d_m || w_rt_d_m)));
    assign w_jr_stall = jr_d && ((we_reg_e && w_rs_d_e) || (load_m && w_rs_d_m));
    assign w_md_stall = (hilo_read_d || md_start_d) && (md_busy || md_start_e);
    assign w_hazard   = w_lw_stall || w_br_stall || w_jr_stall || w_md_stall;

    // A memory freeze masks the hazard; it is re-evaluated once the freeze ends.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (dmem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (w_hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // The mul/div unit keeps counting through a memory freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt <= '0;
        end else if (md_start_e && !dmem_stall) begin
            r_md_cnt <= MD_W'(MD_LATENCY);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - MD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_haz_cnt <= '0;
            r_mem_cnt <= '0;
        end else if (cnt_clr) begin
            r_haz_cnt <= '0;
            r_mem_cnt <= '0;
        end else begin
            if (w_hazard && !dmem_stall && (r_haz_cnt != '1))
                r_haz_cnt <= r_haz_cnt + CNT_W'(1);
            if (dmem_stall && (r_mem_cnt != '1))
                r_mem_cnt <= r_mem_cnt + CNT_W'(1);
        end
    end

    assign hazard_stall_cnt = r_haz_cnt;
    assign mem_stall_cnt    = r_mem_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: table of combinational vectors
// plus hand-written multi-cycle sequences (mul/div window, freeze, counters, reset).
module tb_hazard_scoreboard;

    localparam int RA_W = 5;
    localparam int MDL  = 4;
    localparam int CW   = 4;

    logic clk, rst_n;
    logic [RA_W-1:0] rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w;
    logic we_reg_e, we_reg_m, we_reg_w, load_e, load_m, branch_d, jr_d;
    logic md_start_d, md_start_e, hilo_read_d, dmem_stall, cnt_clr;
    logic [1:0] forward_ae, forward_be;
    logic forward_ad, forward_bd;
    logic stall_f, stall_d, stall_e, stall_m, flush_e, flush_w, md_busy;
    logic [CW-1:0] hazard_stall_cnt, mem_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    hazard_scoreboard #(.RA_W(RA_W), .MD_LATENCY(MDL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w),
        .we_reg_e(we_reg_e), .we_reg_m(we_reg_m), .we_reg_w(we_reg_w),
        .load_e(load_e), .load_m(load_m), .branch_d(branch_d), .jr_d(jr_d),
        .md_start_d(md_start_d), .md_start_e(md_start_e),
        .hilo_read_d(hilo_read_d), .dmem_stall(dmem_stall), .cnt_clr(cnt_clr),
        .forward_ae(forward_ae), .forward_be(forward_be),
        .forward_ad(forward_ad), .forward_bd(forward_bd),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_e(flush_e), .flush_w(flush_w), .md_busy(md_busy),
        .hazard_stall_cnt(hazard_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // st = {stall_f, stall_d, stall_e, stall_m, flush_e, flush_w}
    typedef struct packed {
        logic [RA_W-1:0] rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w;
        logic [2:0] we;
        logic [1:0] ld;
        logic br, jr, mds, hilo, dm;
        logic [1:0] fae, fbe;
        logic fad, fbd;
        logic [5:0] st;
    } vec_t;

    localparam logic [5:0] ST_NONE = 6'b000000;
    localparam logic [5:0] ST_HAZ  = 6'b110010;
    localparam logic [5:0] ST_MEM  = 6'b111101;

    vec_t tv[$];
    vec_t t;

    function automatic logic [5:0] st_now();
        return {stall_f, stall_d, stall_e, stall_m, flush_e, flush_w};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
        wa_e = '0; wa_m = '0; wa_w = '0;
        we_reg_e = 0; we_reg_m = 0; we_reg_w = 0; load_e = 0; load_m = 0;
        branch_d = 0; jr_d = 0; md_start_d = 0; md_start_e = 0;
        hilo_read_d = 0; dmem_stall = 0; cnt_clr = 0;
    endtask

    task automatic drive(input vec_t v);
        idle();
        rs_d = v.rs_d; rt_d = v.rt_d; rs_e = v.rs_e; rt_e = v.rt_e;
        wa_e = v.wa_e; wa_m = v.wa_m; wa_w = v.wa_w;
        {we_reg_e, we_reg_m, we_reg_w} = v.we;
        {load_e, load_m} = v.ld;
        branch_d = v.br; jr_d = v.jr; md_start_d = v.mds;
        hilo_read_d = v.hilo; dmem_stall = v.dm;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_h, exp_m;
        idle();
        rst_n = 1'b0;
        #2;
        chk("reset_md_busy", 32'(md_busy), 32'd0);
        chk("reset_hcnt", 32'(hazard_stall_cnt), 32'd0);
        chk("reset_mcnt", 32'(mem_stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        t = '0; t.rs_e = 3; t.wa_m = 3; t.wa_w = 3; t.we = 3'b011; t.fae = 2'b10; tv.push_back(t);
        t = '0; t.rt_e = 3; t.wa_m = 3; t.wa_w = 3; t.we = 3'b011; t.fbe = 2'b10; tv.push_back(t);
        t = '0; t.rs_e = 4; t.rt_e = 4; t.wa_m = 4; t.wa_w = 4; t.we = 3'b001;
        t.fae = 2'b01; t.fbe = 2'b01; tv.push_back(t);
        t = '0; t.rs_d = 6; t.rt_d = 6; t.wa_m = 6; t.we = 3'b010; t.fad = 1; t.fbd = 1; tv.push_back(t);
        t = '0; t.ld = 2'b10; t.wa_e = 5; t.rt_d = 5; t.st = ST_HAZ; tv.push_back(t);
        t = '0; t.ld = 2'b10; t.wa_e = 0; tv.push_back(t);
        t = '0; t.br = 1; t.rs_d = 7; t.ld = 2'b01; t.wa_m = 7; t.st = ST_HAZ; tv.push_back(t);
        t = '0; t.br = 1; t.rs_d = 7; t.we = 3'b100; t.wa_e = 7; t.st = ST_HAZ; tv.push_back(t);
        t = '0; t.br = 1; t.rs_d = 7; t.wa_e = 7; tv.push_back(t);
        t = '0; t.jr = 1; t.rt_d = 9; t.we = 3'b100; t.wa_e = 9; tv.push_back(t);
        t = '0; t.jr = 1; t.rs_d = 9; t.we = 3'b100; t.wa_e = 9; t.st = ST_HAZ; tv.push_back(t);
        t = '0; t.dm = 1; t.ld = 2'b10; t.wa_e = 5; t.rs_d = 5; t.st = ST_MEM; tv.push_back(t);
        t = '0; t.dm = 1; t.st = ST_MEM; tv.push_back(t);
        t = '0; t.mds = 1; tv.push_back(t);
        t = '0; t.br = 1; t.we = 3'b100; tv.push_back(t);

        next_cycle();
        cnt_clr = 1'b1;
        exp_h = 0; exp_m = 0;
        foreach (tv[i]) begin
            next_cycle();
            drive(tv[i]);
            @(negedge clk);
            chk($sformatf("v%0d_fae", i), 32'(forward_ae), 32'(tv[i].fae));
            chk($sformatf("v%0d_fbe", i), 32'(forward_be), 32'(tv[i].fbe));
            chk($sformatf("v%0d_fad", i), 32'(forward_ad), 32'(tv[i].fad));
            chk($sformatf("v%0d_fbd", i), 32'(forward_bd), 32'(tv[i].fbd));
            chk($sformatf("v%0d_st", i), 32'(st_now()), 32'(tv[i].st));
            if (tv[i].st == ST_HAZ) exp_h++;
            if (tv[i].st == ST_MEM) exp_m++;
        end
        next_cycle();
        idle();
        chk("tbl_hcnt", 32'(hazard_stall_cnt), 32'(exp_h));
        chk("tbl_mcnt", 32'(mem_stall_cnt), 32'(exp_m));

        // Branch on an EX producer stalls, then resolves by MEM forwarding.
        branch_d = 1; rs_d = 7; we_reg_e = 1; wa_e = 7;
        @(negedge clk);
        chk("br_e_stall", 32'(st_now()), 32'(ST_HAZ));
        next_cycle();
        we_reg_e = 0; wa_e = 0; we_reg_m = 1; wa_m = 7;
        @(negedge clk);
        chk("br_m_stall", 32'(st_now()), 32'(ST_NONE));
        chk("br_m_fad", 32'(forward_ad), 32'd1);
        next_cycle();
        idle();

        // mfhi behind mult: stalls cycles N..N+4, busy N+1..N+4, free at N+5.
        cnt_clr = 1;
        next_cycle();
        idle();
        md_start_e = 1; hilo_read_d = 1;
        for (int k = 0; k <= MDL + 1; k++) begin
            @(negedge clk);
            chk($sformatf("md_stall_c%0d", k), 32'(stall_d), 32'(k <= MDL));
            chk($sformatf("md_busy_c%0d", k), 32'(md_busy), 32'(k >= 1 && k <= MDL));
            next_cycle();
            md_start_e = 0;
        end
        chk("md_hcnt", 32'(hazard_stall_cnt), 32'(MDL + 1));
        idle();

        // Freeze over a load-use hazard: 3 frozen cycles, hazard count untouched.
        cnt_clr = 1;
        next_cycle();
        idle();
        load_e = 1; wa_e = 5; rt_d = 5; dmem_stall = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("frz_st_c%0d", k), 32'(st_now()), 32'(ST_MEM));
            next_cycle();
        end
        dmem_stall = 0;
        @(negedge clk);
        chk("frz_mcnt", 32'(mem_stall_cnt), 32'd3);
        chk("frz_hcnt", 32'(hazard_stall_cnt), 32'd0);
        chk("frz_release_st", 32'(st_now()), 32'(ST_HAZ));
        next_cycle();
        idle();

        // md_start_e held under a freeze loads only once the freeze lifts.
        md_start_e = 1; dmem_stall = 1;
        next_cycle();
        chk("md_hold_busy0", 32'(md_busy), 32'd0);
        next_cycle();
        chk("md_hold_busy1", 32'(md_busy), 32'd0);
        dmem_stall = 0;
        next_cycle();
        md_start_e = 0;
        chk("md_hold_busy2", 32'(md_busy), 32'd1);
        next_cycle();
        idle();

        // Saturation at 15, then synchronous clear.
        cnt_clr = 1;
        next_cycle();
        idle();
        load_e = 1; wa_e = 2; rs_d = 2;
        for (int k = 0; k < 20; k++) next_cycle();
        idle();
        chk("sat_hcnt", 32'(hazard_stall_cnt), 32'd15);
        cnt_clr = 1; load_e = 1; wa_e = 2; rs_d = 2;
        next_cycle();
        idle();
        chk("clr_hcnt", 32'(hazard_stall_cnt), 32'd0);

        // Asynchronous reset aborts a busy window without a clock edge.
        md_start_e = 1;
        next_cycle();
        md_start_e = 0;
        next_cycle();
        chk("pre_rst_busy", 32'(md_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(md_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline hazard unit for the 5-stage MIPS core, the successor to the combinational hazard unit. It keeps MEM/WB forwarding and the load-use, branch and jr stall rules. It adds a busy scoreboard for a multi-cycle mul/div unit, a whole-pipeline freeze for data-memory wait states, and saturating stall performance counters. It sits beside the datapath and drives the forwarding muxes and the stall/flush pins of every pipeline register.

## Interface
- RA_W, 5, register-address width; index 0 is the hard-wired zero register.
- MD_LATENCY, 8, mul/div busy cycles after issue; legal range ≥1.
- CNT_W, 32, performance-counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rs_d, rt_d  in  RA_W  source registers in DE.
- rs_e, rt_e  in  RA_W  source registers in EX.
- wa_e, wa_m, wa_w  in  RA_W  destination registers in EX/MEM/WB.
- we_reg_e, we_reg_m, we_reg_w  in  1  register write enables per stage.
- load_e, load_m  in  1  load instruction in EX / MEM.
- branch_d, jr_d  in  1  branch / jr resolving in DE.
- md_start_d, md_start_e  in  1  mult/div instruction in DE / EX.
- hilo_read_d  in  1  mfhi/mflo in DE.
- dmem_stall  in  1  data memory not ready this cycle.
- cnt_clr  in  1  synchronous counter clear.
- forward_ae, forward_be  out  2  EX operand select: 10 = MEM, 01 = WB, 00 = register file.
- forward_ad, forward_bd  out  1  DE comparator operand from MEM.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the PC and the IF/DE, DE/EX, EX/MEM registers.
- flush_e, flush_w  out  1  load a bubble into DE/EX and MEM/WB.
- md_busy  out  1  mul/div result not yet valid.
- hazard_stall_cnt, mem_stall_cnt  out  CNT_W  stall cycle counters.

## Operation
- Forwarding is combinational. A source register equal to 0 never forwards.
  - forward_ae/be: MEM match with we_reg_m gives 10, else WB match with we_reg_w gives 01, else 00. MEM wins when both match.
  - forward_ad/bd: MEM match with we_reg_m only.
- A "hit" is a match with a nonzero register.
- Stall causes, all combinational:
  - lw_stall = load_e & wa_e≠0 & (rs_d==wa_e | rt_d==wa_e).
  - br_stall = branch_d & [(we_reg_e & hit of rs_d/rt_d on wa_e) | (load_m & hit of rs_d/rt_d on wa_m)].
  - jr_stall = the same as br_stall, using jr_d and rs_d only.
  - md_stall = (hilo_read_d | md_start_d) & (md_busy | md_start_e).
- hazard = lw_stall | br_stall | jr_stall | md_stall.
- Output priority:
  - dmem_stall=1: stall_f/d/e/m=1, flush_e=0, flush_w=1. The hazard is masked and re-evaluated after the freeze.
  - Else hazard=1: stall_f=stall_d=1, flush_e=1, stall_e=stall_m=flush_w=0.
  - Else all stall/flush outputs are 0.
- Mul/div scoreboard: counter md_cnt, wide enough to hold MD_LATENCY.
  - md_start_e & !dmem_stall loads md_cnt with MD_LATENCY. Load has priority over decrement.
  - Otherwise, if md_cnt≠0, md_cnt decrements, including during dmem_stall, because the unit runs independently.
  - md_busy = (md_cnt≠0).
- Counters:
  - hazard_stall_cnt increments on cycles with hazard & !dmem_stall.
  - mem_stall_cnt increments on cycles with dmem_stall.
  - Both saturate at 2^CNT_W−1.
  - cnt_clr zeroes both and has priority over increment.

## Timing
- Reset (rst_n low, asynchronous): md_cnt=0, md_busy=0, both counters 0. Combinational outputs follow their inputs with md_busy=0.
- Reset mid-operation aborts any mul/div busy window immediately.
- All stall/flush/forward outputs are combinational, same cycle as their inputs, with no register stage.
- md_start_e accepted in cycle N gives:
  - md_busy high in cycles N+1 … N+MD_LATENCY;
  - a dependent mfhi in DE stalls in cycles N … N+MD_LATENCY and advances in N+MD_LATENCY+1.
- A back-to-back md_start_d behind an accepted md_start_e follows the same window.
- md_start_e held under dmem_stall loads only in the first cycle where dmem_stall=0.
- Counters update at the rising clk edge following the qualifying cycle.

## Test plan
- Forwarding: rs_e=3 with wa_m=3 & we_reg_m, and wa_w=3 & we_reg_w → forward_ae=10. Same stimulus with rs_e=0 → forward_ae=00.
- Load-use: load_e, wa_e=5, rt_d=5 → stall_f=stall_d=flush_e=1 for one cycle and hazard_stall_cnt +1. With wa_e=0 → no stall.
- Branch: branch_d, rs_d=7, load_m, wa_m=7 → stall for 1 cycle. With we_reg_e, wa_e=7 → stall, then forward_ad=1 the next cycle.
- Mul/div, MD_LATENCY=4: md_start_e at cycle 10 and hilo_read_d held from cycle 10 → stall during cycles 10–14, released at 15, md_busy high in cycles 11–14.
- Memory wait: dmem_stall high for 3 cycles while lw_stall is active → stall_f/d/e/m=1, flush_e=0, flush_w=1. mem_stall_cnt reaches 3 and hazard_stall_cnt is unchanged.
- Counters and reset: with CNT_W=4, 20 stall cycles → counter saturates at 15. cnt_clr → 0. rst_n low mid-busy → md_busy=0 immediately.
